// File: rtl/alu_seg_display.sv
// 4-bit calculator ALU with a registered result/flag word and a multiplexed common-anode 7-segment driver.
// Define ALU_DIV_EN to include the divide operation; without it the arif bit3 selector decodes as no-op.
module alu_seg_display #(
  parameter int REG_W       = 4,
  parameter int OP_W        = 4,
  parameter int KEY_W       = 2,
  parameter int ANODES      = 4,
  parameter int SEG_W       = 8,
  parameter int REFRESH_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  reg_1,
  input  logic [REG_W-1:0]  reg_2,
  input  logic [OP_W-1:0]   arif,
  input  logic [REG_W-1:0]  ind_from_sw,
  input  logic [KEY_W-1:0]  keys,
  output logic [10:0]       ind_con,
  output logic [2:0]        control,
  output logic [ANODES-1:0] anodes,
  output logic [SEG_W-1:0]  segments
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (ANODES > 1) ? $clog2(ANODES) : 1;

  localparam logic [SEG_W-1:0] SEG_BLANK = '1;
  localparam logic [SEG_W-1:0] SEG_MINUS = SEG_W'(8'hBF);
  localparam logic [SEG_W-1:0] SEG_E     = SEG_W'(8'h86);
  localparam logic [SEG_W-1:0] SEG_R     = SEG_W'(8'hAF);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } op_t;

  op_t        op;
  logic [7:0] mag;
  logic       neg;
  logic       err;

  // Lowest-index zero bit of the active-low selector wins.
  always_comb begin
    op = OP_NONE;
    if (!arif[0])      op = OP_ADD;
    else if (!arif[1]) op = OP_SUB;
    else if (!arif[2]) op = OP_MUL;
`ifdef ALU_DIV_EN
    else if (!arif[3]) op = OP_DIV;
`endif
  end

`ifndef ALU_DIV_EN
  logic unused_div_sel;
  assign unused_div_sel = arif[3];
`endif

  always_comb begin
    mag = '0;
    neg = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD: mag = 8'(reg_1) + 8'(reg_2);
      OP_SUB: begin
        if (reg_2 > reg_1) begin
          mag = 8'(reg_2 - reg_1);
          neg = 1'b1;
        end else begin
          mag = 8'(reg_1 - reg_2);
        end
      end
      OP_MUL: mag = 8'(reg_1) * 8'(reg_2);
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (reg_2 == '0) err = 1'b1;
        else             mag = 8'(reg_1 / reg_2);
      end
`endif
      default: mag = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ind_con <= '0;
      control <= '0;
    end else begin
      ind_con <= {op != OP_NONE, err, neg, mag};
      control <= op;
    end
  end

  // Display source: live switches while a key is held or no op is active.
  logic       show_sw;
  logic [7:0] disp_val;
  logic       disp_neg;
  logic       disp_err;
  logic [7:0] hund;
  logic [7:0] tens;
  logic [7:0] ones;

  always_comb begin
    show_sw  = !(&keys) || (control == 3'd0);
    disp_val = show_sw ? 8'(ind_from_sw) : ind_con[7:0];
    disp_neg = !show_sw && ind_con[8];
    disp_err = !show_sw && ind_con[9];
    hund     = disp_val / 8'd100;
    tens     = (disp_val / 8'd10) % 8'd10;
    ones     = disp_val % 8'd10;
  end

  function automatic logic [SEG_W-1:0] seg_code(input logic [7:0] d);
    logic [7:0] pat;
    case (d)
      8'd0:    pat = 8'hC0;
      8'd1:    pat = 8'hF9;
      8'd2:    pat = 8'hA4;
      8'd3:    pat = 8'hB0;
      8'd4:    pat = 8'h99;
      8'd5:    pat = 8'h92;
      8'd6:    pat = 8'h82;
      8'd7:    pat = 8'hF8;
      8'd8:    pat = 8'h80;
      8'd9:    pat = 8'h90;
      default: pat = 8'hFF;
    endcase
    return SEG_W'(pat);
  endfunction

  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [SEG_W-1:0] seg_next;

  always_comb begin
    seg_next = SEG_BLANK;
    if (disp_err) begin
      case (scan_idx)
        IDX_W'(0): seg_next = SEG_R;
        IDX_W'(1): seg_next = SEG_R;
        IDX_W'(2): seg_next = SEG_E;
        default:   seg_next = SEG_BLANK;
      endcase
    end else begin
      case (scan_idx)
        IDX_W'(0): seg_next = seg_code(ones);
        IDX_W'(1): if (hund != 8'd0 || tens != 8'd0) seg_next = seg_code(tens);
        IDX_W'(2): if (hund != 8'd0) seg_next = seg_code(hund);
        IDX_W'(3): if (disp_neg) seg_next = SEG_MINUS;
        default:   seg_next = SEG_BLANK;
      endcase
    end
  end

  // Anode and segment registers load together at the counter wrap so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      anodes      <= '1;
      segments    <= '1;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      anodes      <= ~(ANODES'(1) << scan_idx);
      segments    <= seg_next;
      scan_idx    <= (scan_idx == IDX_W'(ANODES - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// Self-checking bench for alu_seg_display: table-driven ALU vectors through a scoreboard queue,
// plus hand-written display, key-override and reset sequences.
module tb_alu_seg_display;
  localparam int RD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reg_1, reg_2, arif, ind_from_sw;
  logic [1:0]  keys;
  logic [10:0] ind_con;
  logic [2:0]  control;
  logic [3:0]  anodes;
  logic [7:0]  segments;

  int checks = 0;
  int errors = 0;

  alu_seg_display #(
    .REG_W(4), .OP_W(4), .KEY_W(2), .ANODES(4), .SEG_W(8), .REFRESH_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .reg_1(reg_1), .reg_2(reg_2), .arif(arif),
    .ind_from_sw(ind_from_sw), .keys(keys), .ind_con(ind_con),
    .control(control), .anodes(anodes), .segments(segments)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  op;
    logic [2:0]  ctl;
    logic [10:0] res;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one ALU vector, queue its expectation, then compare one cycle later.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    reg_1 = v.a;
    reg_2 = v.b;
    arif  = v.op;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check({name, "_control"}, 32'(control), 32'(e.ctl));
    check({name, "_ind_con"}, 32'(ind_con), 32'(e.res));
  endtask

  // Wait for a fresh load of digit idx, then compare its segment pattern.
  task automatic wait_digit(input int idx, input logic [7:0] exp, input string name);
    logic [3:0] tgt;
    logic [3:0] prev;
    bit hit;
    tgt  = ~(4'b0001 << idx);
    prev = anodes;
    hit  = 0;
    for (int k = 0; k < RD * 8 + 4; k++) begin
      @(negedge clk);
      if (anodes == tgt && prev != tgt) begin
        hit = 1;
        break;
      end
      prev = anodes;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for anode %0d, anodes=%b", name, idx, anodes);
    end else begin
      check(name, 32'(segments), 32'(exp));
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_anodes"},   32'(anodes),   32'h0000000F);
    check({name, "_segments"}, 32'(segments), 32'h000000FF);
    check({name, "_ind_con"},  32'(ind_con),  32'h0);
    check({name, "_control"},  32'(control),  32'h0);
  endtask

  task automatic first_load(input string name, input logic [7:0] exp_seg);
    int first;
    first = -1;
    for (int k = 1; k <= RD * 4; k++) begin
      @(negedge clk);
      if (anodes != 4'hF) begin
        first = k;
        break;
      end
    end
    check({name, "_cycles"}, 32'(first), 32'(RD));
    check({name, "_anodes"}, 32'(anodes), 32'h0000000E);
    check({name, "_seg"},    32'(segments), 32'(exp_seg));
  endtask

  initial begin
    vec_t v;

    vecs[0]  = '{4'd9,  4'd7,  4'b1110, 3'd1, 11'h410};
    vecs[1]  = '{4'd3,  4'd12, 4'b1101, 3'd2, 11'h509};
    vecs[2]  = '{4'd12, 4'd3,  4'b1101, 3'd2, 11'h409};
    vecs[3]  = '{4'd15, 4'd15, 4'b1011, 3'd3, 11'h4E1};
    vecs[4]  = '{4'd15, 4'd15, 4'b1010, 3'd1, 11'h41E};
    vecs[5]  = '{4'd5,  4'd5,  4'b1111, 3'd0, 11'h000};
    vecs[6]  = '{4'd7,  4'd7,  4'b1101, 3'd2, 11'h400};
    vecs[7]  = '{4'd0,  4'd0,  4'b0000, 3'd1, 11'h400};
    vecs[8]  = '{4'd15, 4'd0,  4'b1001, 3'd2, 11'h40F};
    vecs[9]  = '{4'd0,  4'd15, 4'b0011, 3'd3, 11'h400};
`ifdef ALU_DIV_EN
    vecs[10] = '{4'd8,  4'd0,  4'b0111, 3'd4, 11'h600};
    vecs[11] = '{4'd13, 4'd4,  4'b0111, 3'd4, 11'h403};
    vecs[12] = '{4'd15, 4'd1,  4'b0111, 3'd4, 11'h40F};
`else
    vecs[10] = '{4'd8,  4'd0,  4'b0111, 3'd0, 11'h000};
    vecs[11] = '{4'd13, 4'd4,  4'b0111, 3'd0, 11'h000};
    vecs[12] = '{4'd15, 4'd1,  4'b0111, 3'd0, 11'h000};
`endif

    rst = 1'b1;
    reg_1 = 4'd0;
    reg_2 = 4'd0;
    arif = 4'b1111;
    keys = 2'b11;
    ind_from_sw = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    first_load("first_digit", 8'hC0);

    for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

    v = '{4'd9, 4'd7, 4'b1110, 3'd1, 11'h410};
    apply(v, "add_disp");
    wait_digit(0, 8'h82, "add_d0");
    wait_digit(1, 8'hF9, "add_d1");
    wait_digit(2, 8'hFF, "add_d2");
    wait_digit(3, 8'hFF, "add_d3");

    v = '{4'd3, 4'd12, 4'b1101, 3'd2, 11'h509};
    apply(v, "sub_disp");
    wait_digit(3, 8'hBF, "sub_d3");
    wait_digit(0, 8'h90, "sub_d0");
    wait_digit(1, 8'hFF, "sub_d1");

    v = '{4'd15, 4'd15, 4'b1011, 3'd3, 11'h4E1};
    apply(v, "mul_disp");
    wait_digit(2, 8'hA4, "mul_d2");
    wait_digit(1, 8'hA4, "mul_d1");
    wait_digit(0, 8'h92, "mul_d0");
    wait_digit(3, 8'hFF, "mul_d3");

    v = '{4'd15, 4'd15, 4'b1010, 3'd1, 11'h41E};
    apply(v, "prio_disp");
    wait_digit(1, 8'hB0, "prio_d1");
    wait_digit(0, 8'hC0, "prio_d0");
    wait_digit(2, 8'hFF, "prio_d2");

    v = '{4'd15, 4'd15, 4'b1011, 3'd3, 11'h4E1};
    apply(v, "key_mul");
    keys = 2'b10;
    ind_from_sw = 4'd13;
    wait_digit(0, 8'hB0, "key_d0");
    wait_digit(1, 8'hF9, "key_d1");
    wait_digit(2, 8'hFF, "key_d2");
    check("key_ind_con", 32'(ind_con), 32'h4E1);
    keys = 2'b11;
    wait_digit(2, 8'hA4, "key_rel_d2");

    v = vecs[10];
    apply(v, "div0");
`ifdef ALU_DIV_EN
    wait_digit(0, 8'hAF, "div0_d0");
    wait_digit(1, 8'hAF, "div0_d1");
    wait_digit(2, 8'h86, "div0_d2");
    wait_digit(3, 8'hFF, "div0_d3");
`else
    wait_digit(0, 8'hB0, "div0_sw_d0");
    wait_digit(1, 8'hF9, "div0_sw_d1");
`endif

    v = '{4'd4, 4'd4, 4'b1111, 3'd0, 11'h000};
    ind_from_sw = 4'd7;
    apply(v, "noop");
    wait_digit(0, 8'hF8, "noop_d0");
    wait_digit(1, 8'hFF, "noop_d1");

    v = '{4'd9, 4'd9, 4'b1011, 3'd3, 11'h451};
    apply(v, "pre_rst");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    arif = 4'b1111;
    rst = 1'b0;
    first_load("rst_first_digit", 8'hF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seg_display.md
# alu_seg_display

Combined 4-bit arithmetic unit and 4-digit multiplexed 7-segment driver for the switch calculator. Takes two stored operands and an active-low operation selector, and produces a registered result with flags. Drives a common-anode display showing either the live switch value or the decimal result. Sits directly under the calculator top level; operand capture stays in the top level.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.
- `REG_W`, 4, operand / switch width
- `OP_W`, 4, operation-select width
- `KEY_W`, 2, key width
- `ANODES`, 4, digit count
- `SEG_W`, 8, segment width {dp,g,f,e,d,c,b,a}
- `REFRESH_DIV`, 16, clk cycles per digit, ≥2

Ports:
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `reg_1` in REG_W: operand A
- `reg_2` in REG_W: operand B
- `arif` in OP_W: operation select, active-low
- `ind_from_sw` in REG_W: live switch value, already inverted by the top level
- `keys` in KEY_W: load keys, active-low
- `ind_con` out 11: ALU result
  - [7:0] magnitude
  - [8] negative
  - [9] error
  - [10] valid
- `control` out 3: active op code (0 none, 1 add, 2 sub, 3 mul, 4 div)
- `anodes` out ANODES: digit enables, active-low
- `segments` out SEG_W: segment pattern, active-low

## Operation
- **Op decode:** the lowest-index zero bit of `arif` selects the operation.
  - bit0: add
  - bit1: sub
  - bit2: mul
  - bit3: div
  - `arif`=4'b1111: no op; `control`=0 and `ind_con`=0.
- **add:** A+B, range 0..30.
- **sub:** |A−B|; negative=1 when B>A.
- **mul:** A*B, range 0..225.
- **div:** floor(A/B).
  - B=0: error=1, magnitude 0.
- valid=1 whenever `control`≠0.
- **Display source:**
  - If any `keys` bit is 0, or `control`=0: show `ind_from_sw` in decimal (0..15).
  - Otherwise show the ALU result.
- **Digit layout:** digit0 is rightmost (ones), then tens, hundreds; digit3 is the sign.
  - Leading zeros are blanked; digit0 always shows.
  - Digit3 shows '-' (0xBF) when negative, else blank (0xFF).
  - Error: digits 2..0 show "Err" (E=0x86, r=0xAF, r=0xAF); digit3 blank.
- **Digit codes:** 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90. dp is always off (bit7=1).
- **Scan:** exactly one anode is low at a time.
  - Index 0→1→2→3→0, advancing after each REFRESH_DIV cycles.
  - `anodes` = ~(1<<index).

## Timing
- **Reset values:**
  - `ind_con`=0, `control`=0
  - `anodes`=4'b1111, `segments`=8'hFF
  - scan index 0, refresh counter 0
- **First digit after reset:** digit0 is first enabled REFRESH_DIV cycles after `rst` deasserts.
- **ALU latency:** inputs are sampled on the edge; `ind_con`/`control` are valid one cycle later. Operand or op changes take effect on the next edge with no hold.
- **Display latency:** `anodes`/`segments` are registered together, so they never mismatch.
  - They load on the edge where the counter wraps (REFRESH_DIV−1→0).
  - The pattern uses the `ind_con`/`control`/`keys`/`ind_from_sw` values present at that edge.
- **Reset mid-operation:** wins over everything; all outputs go to reset values on that edge.
- **Decimal conversion:** combinational from registered `ind_con`; no extra latency.

## Configuration
- **`ALU_DIV_EN` defined:** the divide op exists as above.
- **`ALU_DIV_EN` undefined:**
  - `arif` bit3-low-only decodes as no op: `control`=0, display shows the switch value.
  - No divider logic is synthesized.
  - Lower-bit priority is unchanged.

## Test plan
- **Reset:** hold `rst` 3 cycles → `anodes`=1111, `segments`=FF, `ind_con`=0; first anode 1110 appears REFRESH_DIV cycles after release.
- **Add:** A=9, B=7, `arif`=1110, `keys`=11 → next cycle `control`=1, `ind_con`=0x410 (valid, 16).
  - Display: digit0=6 (82), digit1=1 (F9), digits 2–3 blank.
- **Sub negative:** A=3, B=12, `arif`=1101 → `control`=2, magnitude 9, negative=1.
  - Display: digit3='-' (BF), digit0=9 (90).
- **Mul max and priority:** A=15, B=15, `arif`=1011 → 225, digits "225".
  - `arif`=1010 → add (priority), shows 30.
- **Divide by zero:** A=8, B=0, `arif`=0111 → error=1, display "Err".
  - Without `ALU_DIV_EN`: `control`=0, switch value shown.
- **Key override:** `keys`=10 during mul, `ind_from_sw`=13 → display "13" while `ind_con` still 225; release keys → "225" at the next digit load.
